// File: rtl/shift_seq_pkg.sv
// Shared types for the sequential shifter: operation codes and FSM states.
// Used by shift_seq_if, shift_seq_step and shift_seq_unit.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    OP_LSL = 3'b000,
    OP_ASL = 3'b001,
    OP_LSR = 3'b010,
    OP_ASR = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101
  } op_e;

  // Reserved codes pass the operand through unchanged.
  localparam logic [2:0] OP_RSV0 = 3'b110;
  localparam logic [2:0] OP_RSV1 = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/shift_seq_if.sv
// Operand/result valid-ready bundle of the sequential shifter.
// Optional out_ovf appears when SHIFT_SEQ_OVF_EN is defined.
interface shift_seq_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [2:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
`ifdef SHIFT_SEQ_OVF_EN
  logic               out_ovf;
`endif

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
`ifdef SHIFT_SEQ_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
`ifdef SHIFT_SEQ_OVF_EN
    , output out_ovf
`endif
  );

endinterface

// File: rtl/shift_seq_step.sv
// One combinational shift step: moves the working value by k bits (0..STEP)
// according to the latched op; fill is the original operand MSB for ASR.
module shift_seq_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] val,
  input  logic [KW-1:0]    k,
  input  logic [2:0]       op,
  input  logic             fill,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] topmask;

  always_comb begin
    topmask = ~({WIDTH{1'b1}} >> k);
    res     = val;
    case (op)
      OP_LSL, OP_ASL: res = val << k;
      OP_LSR:         res = val >> k;
      OP_ASR:         res = (val >> k) | ({WIDTH{fill}} & topmask);
      // A shift by WIDTH yields zero, so k=0 degenerates to a plain copy.
      OP_ROL:         res = (val << k) | (val >> (WIDTH - int'(k)));
      OP_ROR:         res = (val >> k) | (val << (WIDTH - int'(k)));
      OP_RSV0, OP_RSV1: res = val;
      default:        res = val;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Area-lean iterative shifter/rotator, STEP bits per clock, valid/ready in and out.
// Define SHIFT_SEQ_OVF_EN to add the out_ovf overflow flag for LSL/ASL.
module shift_seq_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic      clk,
  input logic      rst,
  shift_seq_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, result_q, stepped;
  logic [SHAMT_W-1:0] remain_q, k;
  logic [2:0]         op_q;
  logic               fill_q;
  logic               accept, last;

  assign k      = (remain_q > STEP_K) ? STEP_K : remain_q;
  assign accept = bus.in_valid && (state_q == IDLE);
  assign last   = (state_q == SHIFT) && (remain_q == k);

  shift_seq_step #(
    .WIDTH (WIDTH),
    .KW    (SHAMT_W)
  ) u_step (
    .val  (work_q),
    .k    (k),
    .op   (op_q),
    .fill (fill_q),
    .res  (stepped)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = (bus.in_shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // result_q only changes on entry to DONE, so out_data keeps the last result while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q   <= '0;
      result_q <= '0;
      remain_q <= '0;
      op_q     <= '0;
      fill_q   <= 1'b0;
    end else if (accept) begin
      work_q   <= bus.in_data;
      remain_q <= bus.in_shamt;
      op_q     <= bus.in_op;
      fill_q   <= bus.in_data[WIDTH-1];
      if (bus.in_shamt == '0) result_q <= bus.in_data;
    end else if (state_q == SHIFT) begin
      work_q   <= stepped;
      remain_q <= remain_q - k;
      if (last) result_q <= stepped;
    end
  end

  assign bus.out_data = result_q;

`ifdef SHIFT_SEQ_OVF_EN
  logic [WIDTH-1:0] lmask, amask, atop;
  logic             ovf_d, ovf_q;

  // Overflow is judged on the original operand: bits shifted out (LSL) or a sign change (ASL).
  always_comb begin
    lmask = ~({WIDTH{1'b1}} >> bus.in_shamt);
    amask = ~({WIDTH{1'b1}} >> (int'(bus.in_shamt) + 1));
    atop  = bus.in_data & amask;
    ovf_d = 1'b0;
    case (bus.in_op)
      OP_LSL:  ovf_d = |(bus.in_data & lmask);
      OP_ASL:  ovf_d = (atop != '0) && (atop != amask);
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         ovf_q <= 1'b0;
    else if (accept) ovf_q <= ovf_d;
  end

  assign bus.out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed scoreboard bench for shift_seq_unit: one STEP=1 and one STEP=3 instance.
// out_ovf is also checked when SHIFT_SEQ_OVF_EN is defined.
module tb_shift_seq_unit;
  import shift_seq_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       ovf;
    logic [7:0] lat;
  } exp_t;

  exp_t sb[$];

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, sel;
  logic [7:0] in_data;
  logic [2:0] in_shamt, in_op;
  int         compared = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  shift_seq_if #(.WIDTH(W)) b1 ();
  shift_seq_if #(.WIDTH(W)) b3 ();

  assign b1.in_valid  = in_valid & ~sel;
  assign b3.in_valid  = in_valid & sel;
  assign b1.in_data   = in_data;
  assign b3.in_data   = in_data;
  assign b1.in_shamt  = in_shamt;
  assign b3.in_shamt  = in_shamt;
  assign b1.in_op     = in_op;
  assign b3.in_op     = in_op;
  assign b1.out_ready = out_ready;
  assign b3.out_ready = out_ready;

  shift_seq_unit #(.WIDTH(W), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  shift_seq_unit #(.WIDTH(W), .STEP(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  logic       o_ready, o_valid;
  logic [7:0] o_data;
  assign o_ready = sel ? b3.in_ready  : b1.in_ready;
  assign o_valid = sel ? b3.out_valid : b1.out_valid;
  assign o_data  = sel ? b3.out_data  : b1.out_data;
`ifdef SHIFT_SEQ_OVF_EN
  logic o_ovf;
  assign o_ovf = sel ? b3.out_ovf : b1.out_ovf;
`endif

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] d, input int sh);
    logic [7:0] r;
    case (op)
      3'd0, 3'd1: r = d << sh;
      3'd2:       r = d >> sh;
      3'd3:       r = $signed(d) >>> sh;
      3'd4:       r = (d << sh) | (d >> (8 - sh));
      3'd5:       r = (d >> sh) | (d << (8 - sh));
      default:    r = d;
    endcase
    return r;
  endfunction

  function automatic logic ovf_model(input logic [2:0] op, input logic [7:0] d, input int sh);
    logic o = 1'b0;
    if (op == 3'd0) begin
      for (int i = 0; i < sh; i++) if (d[7-i]) o = 1'b1;
    end else if (op == 3'd1) begin
      for (int i = 1; i <= sh; i++) if (d[7-i] != d[7]) o = 1'b1;
    end
    return o;
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] d, input logic [2:0] sh,
                               input bit push);
    exp_t e;
    int   n = 0;
    int   step = sel ? 3 : 1;
    @(negedge clk);
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    compare("accept_ready", o_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.data = model(op, d, int'(sh));
      e.ovf  = ovf_model(op, d, int'(sh));
      e.lat  = 8'((int'(sh) + step - 1) / step);
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(input int hold, input bit junk);
    exp_t e;
    int   cyc = 0;
    out_ready = (hold == 0);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_shamt = 3'd5;
      in_op    = 3'd4;
    end
    @(negedge clk);
    compare("busy_in_ready", o_ready, 0);
    while (!o_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    compare("latency", cyc, e.lat);
    compare("out_valid", o_valid, 1);
    compare("out_data", o_data, e.data);
`ifdef SHIFT_SEQ_OVF_EN
    compare("out_ovf", o_ovf, e.ovf);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      compare("hold_valid", o_valid, 1);
      compare("hold_data", o_data, e.data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    compare("release_ready", o_ready, 1);
    compare("release_valid", o_valid, 0);
    compare("release_data", o_data, e.data);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    in_data = '0; in_shamt = '0; in_op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      compare("reset_in_ready", o_ready, 1);
      compare("reset_out_valid", o_valid, 0);
      compare("reset_out_data", o_data, 0);
`ifdef SHIFT_SEQ_OVF_EN
      compare("reset_out_ovf", o_ovf, 0);
`endif
    end
    sel = 1'b0;
    rst = 1'b0;
    $display("[TB] STEP=1 operations");

    applyStimulus(3'd0, 8'h96, 3'd2, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd3, 8'h96, 3'd3, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd2, 8'h96, 3'd3, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd4, 8'h96, 3'd3, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd5, 8'h96, 3'd1, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd1, 8'h96, 3'd0, 1'b1); checkOutput(0, 1'b1);
    applyStimulus(3'd6, 8'h96, 3'd4, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd2, 8'h96, 3'd5, 1'b1); checkOutput(5, 1'b1);
    applyStimulus(3'd4, 8'h96, 3'd7, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd3, 8'h6A, 3'd7, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd3, 8'h80, 3'd7, 1'b1); checkOutput(0, 1'b1);
    applyStimulus(3'd1, 8'h30, 3'd2, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd1, 8'h08, 3'd2, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd0, 8'h40, 3'd2, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd5, 8'h96, 3'd3, 1'b1); checkOutput(0, 1'b0);

    $display("[TB] STEP=3 operations");
    sel = 1'b1;
    applyStimulus(3'd0, 8'h01, 3'd7, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd0, 8'h01, 3'd3, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd3, 8'h96, 3'd5, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd5, 8'h96, 3'd4, 1'b1); checkOutput(2, 1'b1);
    applyStimulus(3'd4, 8'h96, 3'd2, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd0, 8'hC1, 3'd6, 1'b1); checkOutput(0, 1'b0);
    applyStimulus(3'd2, 8'h96, 3'd0, 1'b1); checkOutput(0, 1'b0);

    $display("[TB] reset abort");
    sel = 1'b0;
    applyStimulus(3'd0, 8'h96, 3'd6, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    compare("abort_in_ready", o_ready, 1);
    compare("abort_out_valid", o_valid, 0);
    compare("abort_out_data", o_data, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen += int'(o_valid);
    end
    compare("abort_no_result", seen, 0);
    applyStimulus(3'd5, 8'h96, 3'd1, 1'b1); checkOutput(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Parametrised, multi-cycle successor to the team's combinational shift/concat operators.
- Accepts one operand, a shift amount and an operation code over a valid/ready handshake.
- Performs the shift iteratively, STEP bits per clock, and returns the result over a valid/ready handshake.
- Supports logical and arithmetic shifts plus rotates. Serves as the area-lean shifter in datapaths where one result per few cycles is acceptable.

Parameters:
- WIDTH, 8, operand/result width; power of two, at least 4.
- STEP, 1, bits shifted per cycle; 1 to WIDTH-1.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  unit can accept an operand.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount, 0 to WIDTH-1.
- in_op  in  3  operation: 000 LSL, 001 ASL, 010 LSR, 011 ASR, 100 ROL, 101 ROR; 110 and 111 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- States:
  - IDLE: in_ready=1.
  - SHIFT: working.
  - DONE: out_valid=1.
  - in_ready = (state==IDLE). out_valid = (state==DONE).
- Reset: state=IDLE, out_data=0, internal data/count/op cleared. After reset, in_ready=1 and out_valid=0.
- Reset asserted in any state aborts the operation; no result is produced.
- Accept when in_valid && in_ready (IDLE only). On that edge, latch in_data, in_shamt and in_op.
  - If in_shamt==0, go directly to DONE with out_data=in_data.
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - Shift the working register by k = min(STEP, remaining) and subtract k from remaining.
  - On the edge where remaining reaches 0, go to DONE.
- Latency:
  - out_valid is first visible after the accept edge plus ceil(shamt/STEP) further edges.
  - For shamt=0, out_valid is visible in the cycle right after the accept edge.
- Operations (n = total shift amount):
  - LSL/ASL: left shift, zero fill. Identical data result.
  - LSR: right shift, zero fill.
  - ASR: right shift, filled with the latched operand MSB.
  - ROL/ROR: rotate by n.
- Reserved op codes pass the operand through unchanged, with the normal latency for the given shamt.
- DONE:
  - out_data and out_valid are held stable while out_ready=0, for any number of cycles.
  - On out_valid && out_ready, go to IDLE.
  - No back-to-back acceptance: in_ready is 0 in DONE, so the earliest next accept is the cycle after the result handshake.
- in_valid while busy (SHIFT or DONE) is ignored; inputs are not sampled.
- in_data/in_shamt/in_op changing after acceptance have no effect.
- out_data is undefined-free: it holds the last result, or 0 after reset, while out_valid=0.

Optional Feature:
- Macro: SHIFT_SEQ_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit, valid with out_valid, reset 0).
  - Computed at accept from the original operand.
  - LSL: ovf=1 if any of the top shamt bits is 1.
  - ASL: ovf=1 if the top shamt+1 bits are not all equal (sign change).
  - All other ops, and shamt=0: ovf=0.
  - Held with out_data.
- Undefined: port absent, no overflow logic.

Decomposition:
- Package shift_seq_pkg:
  - op enum typedef (LSL, ASL, LSR, ASR, ROL, ROR).
  - state enum typedef (IDLE, SHIFT, DONE).
  - op code constants.
- Sub-module shift_seq_step: combinational single step shifting the working value by k (0 to STEP) for a given op and fill bit. Instantiated once in the shift datapath.

Test Plan:
- WIDTH=8, STEP=1, LSL, 8'h96, shamt 2 -> out_data=8'h58; out_valid 2 edges after accept; in_ready=0 throughout.
- STEP=1, 8'h96 with: ASR shamt 3 -> 8'hF2; LSR shamt 3 -> 8'h12; ROL shamt 3 -> 8'hB4; ROR shamt 1 -> 8'h4B; shamt 0, any op -> 8'h96 one cycle after accept.
- STEP=3, LSL, 8'h01, shamt 7 -> 8'h80 after 3 shift edges; shamt 3 -> 8'h08 after 1 edge.
- Backpressure: hold out_ready=0 for 5 cycles -> out_data/out_valid stable. Pulse in_valid with new data during SHIFT/DONE -> ignored. After the handshake, in_ready=1 the next cycle.
- Reset: assert rst during SHIFT (LSL 8'h96 shamt 6, after 2 edges) -> next cycle IDLE, out_valid=0, out_data=0, in_ready=1; a following op completes correctly.
- With SHIFT_SEQ_OVF_EN: ASL 8'h30 shamt 2 -> 8'hC0, out_ovf=1; ASL 8'h08 shamt 2 -> 8'h20, out_ovf=0; LSL 8'h40 shamt 2 -> 8'h00, out_ovf=1; ROR any -> out_ovf=0.
